// File: rtl/number_analyzer_pkg.sv
// Shared definitions for the number analyzer sequencer: controller states,
// default number width and the index of each attached analyzer unit.
package number_analyzer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Position of each analyzer unit on the go/done/result vectors
  localparam int UNIT_FIB    = 0;
  localparam int UNIT_EVEN   = 1;
  localparam int UNIT_PRIME  = 2;
  localparam int UNIT_SQUARE = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_RUN     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

endpackage

// File: rtl/number_analyzer_next_unit.sv
// Priority search: lowest enabled unit index at or above the current index.
// none_left is raised when no enabled unit remains (including idx past the end).
module number_analyzer_next_unit #(
  parameter int NUM_UNITS = 4,
  parameter int IDX_W     = $clog2(NUM_UNITS) + 1
) (
  input  logic [NUM_UNITS-1:0] mask,
  input  logic [IDX_W-1:0]     idx,
  output logic [IDX_W-1:0]     next_idx,
  output logic                 none_left
);

  // Scan from the top down so the lowest qualifying index is the one kept
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // a combinational output unassigned would infer a latch.
    next_idx  = '0;
    none_left = 1'b1;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) >= idx)) begin
        next_idx  = IDX_W'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/number_analyzer_sequencer.sv
// Runs one number through a bank of analyzer units, one unit at a time,
// using a go/done handshake per unit and collecting each 1-bit verdict.
// Optional watchdog: define NUMBER_ANALYZER_WATCHDOG_EN to abort a unit that
// stays in RUN for TIMEOUT_CYCLES cycles without raising done.
module number_analyzer_sequencer
  import number_analyzer_pkg::*;
#(
  parameter int NUM_UNITS      = 4,
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     number_i,
  input  logic [NUM_UNITS-1:0] mask_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NUM_UNITS-1:0] flags_o,
  output logic [NUM_UNITS-1:0] timeout_o,
  output logic [NUM_UNITS-1:0] unit_go_o,
  output logic [WIDTH-1:0]     unit_number_o,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  input  logic [NUM_UNITS-1:0] unit_result_i
);

  // One extra bit so idx can step past the last unit without wrapping
  localparam int IDX_W = $clog2(NUM_UNITS) + 1;

  if (NUM_UNITS < 1 || NUM_UNITS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("number_analyzer_sequencer: NUM_UNITS must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, next_idx;
  logic                   none_left;
  logic [NUM_UNITS-1:0]   mask_q, flags_q, cur_onehot;
  logic [WIDTH-1:0]       number_q;
  logic                   done_sel, result_sel;
  logic                   wd_expire, timed_out;

  // Only the unit currently addressed by idx is listened to
  assign cur_onehot = NUM_UNITS'(1) << idx_q;
  assign done_sel   = |(unit_done_i & cur_onehot);
  assign result_sel = |(unit_result_i & cur_onehot);

  number_analyzer_next_unit #(
    .NUM_UNITS (NUM_UNITS),
    .IDX_W     (IDX_W)
  ) u_next_unit (
    .mask      (mask_q),
    .idx       (idx_q),
    .next_idx  (next_idx),
    .none_left (none_left)
  );

`ifdef NUMBER_ANALYZER_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]     wd_cnt_q;
  logic                 timed_out_q;
  logic [NUM_UNITS-1:0] timeout_q;

  // Expires on the TIMEOUT_CYCLES-th RUN cycle if done is still low
  assign wd_expire = (state_q == ST_RUN) && !done_sel &&
                     (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timed_out = timed_out_q;
  assign timeout_o = timeout_q;

  // Watchdog counter, sticky per-unit timeout flags, and RELEASE bypass flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q    <= '0;
      timed_out_q <= 1'b0;
      timeout_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE:    if (start_i) timeout_q <= '0;
        ST_SELECT:  wd_cnt_q <= '0;
        ST_RUN: begin
          if (wd_expire) begin
            timeout_q   <= timeout_q | cur_onehot;
            timed_out_q <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        ST_RELEASE: if (state_d == ST_SELECT) timed_out_q <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timed_out = 1'b0;
  assign timeout_o = '0;
`endif

  // State register; reset is synchronous
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_SELECT;
      ST_SELECT:  state_d = none_left ? ST_FINISH : ST_RUN;
      ST_RUN:     if (done_sel || wd_expire) state_d = ST_RELEASE;
      ST_RELEASE: if (!done_sel || timed_out) state_d = ST_SELECT;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request latching, unit index stepping and verdict capture
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      mask_q   <= '0;
      number_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            number_q <= number_i;
            mask_q   <= mask_i;
            flags_q  <= '0;
            idx_q    <= '0;
          end
        end
        ST_SELECT: idx_q <= next_idx;
        ST_RUN: begin
          if (done_sel)
            flags_q <= (flags_q & ~cur_onehot) | (cur_onehot & {NUM_UNITS{result_sel}});
          else if (wd_expire)
            flags_q <= flags_q & ~cur_onehot;
        end
        ST_RELEASE: if (state_d == ST_SELECT) idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_FINISH);
  assign flags_o       = flags_q;
  assign unit_go_o     = (state_q == ST_RUN) ? cur_onehot : '0;
  assign unit_number_o = number_q;

endmodule

// File: tb/tb_number_analyzer_sequencer.sv
// Self-checking bench for number_analyzer_sequencer: mock analyzer units with
// configurable latency / done hold-over / verdict, a scoreboard queue filled
// at start time from a run-level model, and a monitor that checks on done_o.
// With NUMBER_ANALYZER_WATCHDOG_EN defined, a never-finishing unit is added.
module tb_number_analyzer_sequencer;
  import number_analyzer_pkg::*;

  localparam int NU       = 4;
  localparam int W        = 32;
  localparam int TO       = 8;
  localparam int MAX_WAIT = 2000;

  typedef struct packed {
    logic [NU-1:0]       flags;
    logic [NU-1:0]       timeout;
    logic [15:0]         cycles;
    logic [W-1:0]        number;
    logic [NU-1:0][15:0] go_cycles;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [W-1:0]  number_i;
  logic [NU-1:0] mask_i;
  logic          busy_o, done_o;
  logic [NU-1:0] flags_o, timeout_o, unit_go_o;
  logic [W-1:0]  unit_number_o;
  logic [NU-1:0] unit_done, unit_result;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Mock unit configuration: lat 0 means the unit never raises done
  int            lat_cfg[NU];
  int            hold_cfg[NU];
  logic [NU-1:0] res_cfg;
  logic [NU-1:0] cur_mask;
  logic [NU-1:0] noise_done, noise_res;
  int            cnt[NU];
  int            hold_left[NU];

  always #5 clk = ~clk;

  number_analyzer_sequencer #(
    .NUM_UNITS      (NU),
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .number_i      (number_i),
    .mask_i        (mask_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .flags_o       (flags_o),
    .timeout_o     (timeout_o),
    .unit_go_o     (unit_go_o),
    .unit_number_o (unit_number_o),
    .unit_done_i   (unit_done),
    .unit_result_i (unit_result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Mock unit outputs: done after lat go-cycles, held hold_cfg cycles past go;
  // verdict is inverted while done is low. Units outside the run mask babble.
  always_comb begin
    unit_done   = '0;
    unit_result = '0;
    for (int i = 0; i < NU; i++) begin
      if (cur_mask[i]) begin
        unit_done[i] = (unit_go_o[i] && lat_cfg[i] != 0 && cnt[i] >= lat_cfg[i] - 1) ||
                       (hold_left[i] > 0);
        unit_result[i] = unit_done[i] ? res_cfg[i] : ~res_cfg[i];
      end else begin
        unit_done[i]   = noise_done[i];
        unit_result[i] = noise_res[i];
      end
    end
  end

  // Mock unit internal counters
  always @(posedge clk) begin
    for (int i = 0; i < NU; i++) begin
      if (reset) begin
        cnt[i]       <= 0;
        hold_left[i] <= 0;
      end else if (unit_go_o[i]) begin
        cnt[i] <= cnt[i] + 1;
        if (unit_done[i]) hold_left[i] <= hold_cfg[i];
      end else begin
        cnt[i] <= 0;
        if (hold_left[i] > 0) hold_left[i] <= hold_left[i] - 1;
      end
    end
  end

  initial begin
    noise_done = '0;
    noise_res  = '0;
    forever begin
      @(negedge clk);
      noise_done = NU'($urandom);
      noise_res  = NU'($urandom);
    end
  end

  // Run-level model: each enabled unit costs SELECT + RUN + RELEASE cycles,
  // plus a final SELECT and FINISH.
  function automatic exp_t model(input logic [NU-1:0] m, input logic [W-1:0] n);
    exp_t e;
    int   cyc;
    e        = '0;
    e.number = n;
    cyc      = 2;
    for (int i = 0; i < NU; i++) begin
      if (m[i]) begin
        if (lat_cfg[i] == 0) begin
          e.timeout[i]   = 1'b1;
          e.go_cycles[i] = 16'(TO);
          cyc += TO + 2;
        end else begin
          e.flags[i]     = res_cfg[i];
          e.go_cycles[i] = 16'(lat_cfg[i]);
          cyc += lat_cfg[i] + hold_cfg[i] + 2;
        end
      end
    end
    e.cycles = 16'(cyc);
    return e;
  endfunction

  // Monitor: per-cycle go/number sanity, and full comparison on every done_o
  initial begin
    int   busy_cnt;
    int   go_cnt[NU];
    bit   prev_done;
    exp_t e;
    busy_cnt  = 0;
    prev_done = 0;
    for (int i = 0; i < NU; i++) go_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt  = 0;
        prev_done = 0;
        for (int i = 0; i < NU; i++) go_cnt[i] = 0;
      end else begin
        if (prev_done) check("busy_after_done", 64'(busy_o), 64'(0));
        prev_done = done_o;
        if (busy_o) begin
          busy_cnt++;
          if (exp_q.size() > 0) check("unit_number", 64'(unit_number_o), 64'(exp_q[0].number));
        end
        if (unit_go_o != '0) begin
          check("go_onehot", 64'($onehot(unit_go_o)), 64'(1));
          check("go_in_mask", 64'(unit_go_o & ~cur_mask), 64'(0));
        end
        for (int i = 0; i < NU; i++) if (unit_go_o[i]) go_cnt[i]++;
        if (done_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done_o=1, expected no pending request (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            check("flags", 64'(flags_o), 64'(e.flags));
            check("timeout", 64'(timeout_o), 64'(e.timeout));
            check("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
            for (int i = 0; i < NU; i++)
              check($sformatf("go_cycles_u%0d", i), 64'(go_cnt[i]), 64'(e.go_cycles[i]));
          end
          busy_cnt = 0;
          for (int i = 0; i < NU; i++) go_cnt[i] = 0;
        end
      end
    end
  end

  task automatic do_start(input logic [NU-1:0] m, input logic [W-1:0] n);
    cur_mask = m;
    exp_q.push_back(model(m, n));
    mask_i   = m;
    number_i = n;
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    mask_i   = NU'($urandom);
    number_i = $urandom;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy_o && c < MAX_WAIT) begin
      @(negedge clk);
      c++;
    end
    if (busy_o) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy_o still 1 after %0d cycles, expected 0", MAX_WAIT);
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic set_all(input int lat, input int hold);
    for (int i = 0; i < NU; i++) begin
      lat_cfg[i]  = lat;
      hold_cfg[i] = hold;
    end
  endtask

  initial begin
    logic [NU-1:0] last_flags;
    int            c;
    reset    = 1'b1;
    start_i  = 1'b0;
    mask_i   = '0;
    number_i = '0;
    cur_mask = '0;
    res_cfg  = '0;
    set_all(5, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_flags", 64'(flags_o), 64'(0));
    check("rst_timeout", 64'(timeout_o), 64'(0));
    check("rst_go", 64'(unit_go_o), 64'(0));
    check("rst_number", 64'(unit_number_o), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Fib and even units, latency 5, number 89
    set_all(5, 0);
    res_cfg = NU'($urandom);
    res_cfg[UNIT_FIB]  = 1'b1;
    res_cfg[UNIT_EVEN] = 1'b0;
    do_start(4'b0011, 32'd89);
    wait_idle();
    check("t1_flags_hold", 64'(flags_o), 64'(4'b0001));

    // Empty mask: SELECT then FINISH
    do_start(4'b0000, $urandom);
    wait_idle();
    check("t2_flags_zero", 64'(flags_o), 64'(0));

    // Unit 3 keeps done high 3 cycles past go
    set_all(3, 0);
    lat_cfg[UNIT_SQUARE]  = 2;
    hold_cfg[UNIT_SQUARE] = 3;
    res_cfg = NU'($urandom);
    do_start(4'b1010, $urandom);
    wait_idle();

    // start_i during RUN is ignored
    set_all(4, 1);
    res_cfg = 4'b0101;
    do_start(4'b0101, 32'hA5A5_0001);
    repeat (3) @(negedge clk);
    mask_i   = 4'b1111;
    number_i = 32'h1234_5678;
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    wait_idle();
    last_flags = 4'b0101;
    repeat (3) @(negedge clk);
    check("t4_flags_hold", 64'(flags_o), 64'(last_flags));
    check("t4_no_second_run", 64'(busy_o), 64'(0));

    // Reset while unit 2 is in RUN
    set_all(6, 0);
    res_cfg = 4'b0100;
    do_start(4'b0100, $urandom);
    c = 0;
    while (!unit_go_o[UNIT_PRIME] && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("t5_reached_run", 64'(unit_go_o[UNIT_PRIME]), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("t5_go", 64'(unit_go_o), 64'(0));
    check("t5_busy", 64'(busy_o), 64'(0));
    check("t5_flags", 64'(flags_o), 64'(0));
    check("t5_done", 64'(done_o), 64'(0));
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    res_cfg = 4'b1110;
    do_start(4'b1110, $urandom);
    wait_idle();

`ifdef NUMBER_ANALYZER_WATCHDOG_EN
    // Unit 1 never answers; watchdog aborts it and unit 2 still runs
    set_all(3, 0);
    lat_cfg[UNIT_EVEN] = 0;
    res_cfg = 4'b0110;
    do_start(4'b0110, $urandom);
    wait_idle();
    check("wd_timeout_hold", 64'(timeout_o), 64'(4'b0010));
    check("wd_flag1_zero", 64'(flags_o[UNIT_EVEN]), 64'(0));
`endif

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NU; i++) begin
        lat_cfg[i]  = int'($urandom_range(6, 1));
        hold_cfg[i] = int'($urandom_range(3, 0));
      end
      res_cfg = NU'($urandom);
      do_start(NU'($urandom), $urandom);
      wait_idle();
      repeat (int'($urandom_range(2, 0))) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard against a hung run
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/number_analyzer_sequencer.md
Name: number_analyzer_sequencer

Overview:
Front-end controller that runs one 32-bit number through a bank of NUM_UNITS analyzer units (fibonacci, even, prime, ...) one unit at a time. It drives each unit's go line and shares one number bus across all units. It collects each unit's 1-bit verdict into a flag vector and signals completion to the system level. Each unit's go/done handshake holds go high until the unit reaches its terminal state; the unit then returns to its initial state once go drops.

Parameters:
NUM_UNITS, 4, number of analyzer units attached (1..16)
WIDTH, 32, width of the analysed number
TIMEOUT_CYCLES, 256, watchdog limit per unit (used only with the optional feature)

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start_i  input  1  request; sampled only in IDLE
number_i  input  WIDTH  number to analyse, latched on accepted start
mask_i  input  NUM_UNITS  units to run (bit i=1 runs unit i), latched on accepted start
busy_o  output  1  high from accepted start until done_o inclusive
done_o  output  1  one-cycle pulse; flags_o valid from this cycle
flags_o  output  NUM_UNITS  per-unit verdicts; skipped units read 0
timeout_o  output  NUM_UNITS  per-unit watchdog-expired flags
unit_go_o  output  NUM_UNITS  one-hot-or-zero go to the units
unit_number_o  output  WIDTH  latched number, broadcast to all units
unit_done_i  input  NUM_UNITS  unit i in terminal state (level)
unit_result_i  input  NUM_UNITS  unit i verdict, valid while unit_done_i[i]=1

Behaviour:
- Reset values: busy_o=0, done_o=0, flags_o=0, timeout_o=0, unit_go_o=0, unit_number_o=0. State=IDLE, idx=0.
- Reset asserted mid-run: the same reset values apply on the next edge. go drops immediately, and partial flags are discarded.
- States and transitions:
  - IDLE: on start_i=1, latch number_i and mask_i, clear flags_o and timeout_o, set idx=0, go to SELECT.
  - SELECT (1 cycle): idx advances to the lowest i >= idx with mask bit set. If none remain, go to FINISH. Otherwise go to RUN.
  - RUN: unit_go_o[idx]=1, all other go bits 0. On the first cycle with unit_done_i[idx]=1, flags_o[idx] <= unit_result_i[idx], then go to RELEASE.
  - RELEASE: unit_go_o=0. Stay in RELEASE until unit_done_i[idx]=0, for at least 1 cycle. Then set idx=idx+1 and go to SELECT.
  - FINISH: done_o=1 for exactly one cycle, then go to IDLE.
- busy_o = (state != IDLE).
- flags_o and timeout_o hold after done_o until the next accepted start.
- start_i while busy_o=1 is ignored; it is not queued.
- Number and mask changes on the inputs after acceptance have no effect on the run in progress.
- mask_i=0: start, then SELECT, then FINISH. done_o rises 2 cycles after the start edge, with flags_o=0.
- Done bits from units other than idx are ignored, including their results.
- A unit whose done is already high at RUN entry is captured on the first RUN cycle; minimum RUN length is 1 cycle.
- Minimum latency per enabled unit: SELECT 1 + RUN k + RELEASE 1 cycles, where k = unit latency.
- idx width is clog2(NUM_UNITS)+1 so that the wrap past the last unit is detected without overflow.

Optional Feature:
Macro NUMBER_ANALYZER_WATCHDOG_EN.
- With the macro: a per-RUN counter clears on RUN entry. If it reaches TIMEOUT_CYCLES with no done:
  - timeout_o[idx] <= 1 and flags_o[idx] <= 0;
  - go to RELEASE, which then exits after 1 cycle regardless of unit_done_i.
- Without the macro: no counter is built, timeout_o is tied 0, and RUN waits indefinitely.

Decomposition:
- Shared package number_analyzer_pkg holds:
  - the state enum (IDLE, SELECT, RUN, RELEASE, FINISH), 3-bit encoding;
  - the default WIDTH;
  - unit index constants (UNIT_FIB=0, UNIT_EVEN=1, UNIT_PRIME=2, UNIT_SQUARE=3).
- One natural sub-module, number_analyzer_next_unit: combinational priority search giving the next enabled index >= idx plus a none-left flag.

Test Plan:
- Mock units with fixed latency 5, mask=4'b0011, number=89 (0x59), fib mock result=1, even mock result=0 -> go[0] high 5 cycles, then go[1] high 5 cycles. done_o pulses once, flags_o=4'b0001, busy_o low the cycle after done_o.
- mask=4'b0000, start -> done_o 2 cycles after the start edge, flags_o=0, unit_go_o never asserted.
- mask=4'b1010, unit 3 mock holds done high for 3 extra cycles after go drops -> RELEASE lasts 4 cycles and unit 0 is never driven. flags_o reflects only units 1 and 3.
- start_i pulsed during RUN with a different number_i -> ignored; unit_number_o unchanged, and exactly one done_o for the first request.
- reset asserted while unit 2 is in RUN -> next edge: unit_go_o=0, busy_o=0, flags_o=0. A new start then completes normally.
- With NUMBER_ANALYZER_WATCHDOG_EN and TIMEOUT_CYCLES=8, unit 1 mock never raises done -> after 8 RUN cycles, timeout_o=4'b0010 and flags_o[1]=0. Unit 2 runs next and done_o still pulses.
